javk_bus_arbiter: RTL and testbench

Shares the JAVK external memory bus (16-bit `addrbus`, 8-bit bidirectional `databus`, `rw`) between two requesters: the `javk` CPU core and a DMA engine. Each requester issues single-byte transactions over a req/ack handshake. The block applies round-robin arbitration, sequences each bus cycle with a programmable number of wait states, and inserts one turnaround cycle between transactions. It sits between `javk`/DMA and the board-level memory bus.

---
 rtl/javk_bus_pkg.sv | 24 ++
 rtl/javk_rr_pick.sv | 28 ++
 rtl/javk_bus_arbiter.sv | 123 ++++++++++++
 tb/tb_javk_bus_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/javk_bus_pkg.sv
// Shared widths, bus direction codes, FSM encoding and request bundle for the
// JAVK external memory bus arbiter.
package javk_bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int WCNT_W = 4;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_TURN   = 2'd2
    } bus_state_t;

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/javk_rr_pick.sv
// Two-requester round-robin pick. ptr names the requester granted last
// (0 = requester 0, 1 = requester 1); on contention the other one wins.
module javk_rr_pick (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       ptr_next
);

    always_comb begin
        gnt      = 2'b00;
        ptr_next = ptr;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
            if (gnt[1])
                ptr_next = 1'b1;
            else if (gnt[0])
                ptr_next = 1'b0;
        end
    end

endmodule

// File: rtl/javk_bus_arbiter.sv
// Arbitrates the JAVK external memory bus between the CPU and a DMA engine:
// round-robin grant, programmable wait states, one turnaround cycle per access.
module javk_bus_arbiter
    import javk_bus_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic              dma_rw,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              cpu_gnt,
    output logic              dma_gnt,
    output logic [ADDR_W-1:0] addrbus,
    output logic              rw,
    inout  wire  [DATA_W-1:0] databus
);

    localparam logic [WCNT_W-1:0] WS_INIT = WCNT_W'(WAIT_STATES);

    bus_state_t        state, state_nxt;
    logic [WCNT_W-1:0] wcnt;
    logic              ptr;
    logic              ptr_nxt;
    logic [1:0]        pick_gnt;
    logic [DATA_W-1:0] wdata_q;
    logic              drive_q;
    bus_req_t          cpu_bundle, dma_bundle, sel_req;

    assign cpu_bundle = '{rw: cpu_rw, addr: cpu_addr, wdata: cpu_wdata};
    assign dma_bundle = '{rw: dma_rw, addr: dma_addr, wdata: dma_wdata};
    assign sel_req    = pick_gnt[1] ? dma_bundle : cpu_bundle;

    // Requests are only looked at in IDLE; index 0 = CPU, 1 = DMA.
    javk_rr_pick u_pick (
        .req      ({dma_req, cpu_req}),
        .ptr      (ptr),
        .en       (state == ST_IDLE),
        .gnt      (pick_gnt),
        .ptr_next (ptr_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (|pick_gnt) state_nxt = ST_ACCESS;
            ST_ACCESS: if (wcnt == '0) state_nxt = ST_TURN;
            ST_TURN:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addrbus <= '0;
            rw      <= RW_READ;
            wdata_q <= '0;
            drive_q <= 1'b0;
            wcnt    <= '0;
            ptr     <= 1'b1;
            cpu_gnt <= 1'b0;
            dma_gnt <= 1'b0;
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            rdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|pick_gnt) begin
                        addrbus <= sel_req.addr;
                        rw      <= sel_req.rw;
                        wdata_q <= sel_req.wdata;
                        drive_q <= (sel_req.rw == RW_WRITE);
                        wcnt    <= WS_INIT;
                        ptr     <= ptr_nxt;
                        cpu_gnt <= pick_gnt[0];
                        dma_gnt <= pick_gnt[1];
                    end
                end
                ST_ACCESS: begin
                    if (wcnt != '0) begin
                        wcnt <= wcnt - 1'b1;
                    end else begin
                        if (rw == RW_READ)
                            rdata <= databus;
                        // Release the bus for the turnaround cycle.
                        rw      <= RW_READ;
                        drive_q <= 1'b0;
                        cpu_ack <= cpu_gnt;
                        dma_ack <= dma_gnt;
                    end
                end
                ST_TURN: begin
                    cpu_gnt <= 1'b0;
                    dma_gnt <= 1'b0;
                    cpu_ack <= 1'b0;
                    dma_ack <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // drive_q is only set for writes and cleared on leaving ACCESS or on reset.
    assign databus = drive_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_javk_bus_arbiter.sv
// Directed bench for javk_bus_arbiter: one WAIT_STATES=1 instance and one
// WAIT_STATES=0 instance, each with a simple memory model on its bus.
module tb_javk_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // WAIT_STATES = 1 instance
    logic        cpu_req = 0, cpu_rw = 1, dma_req = 0, dma_rw = 1;
    logic [15:0] cpu_addr = 0, dma_addr = 0;
    logic [7:0]  cpu_wdata = 0, dma_wdata = 0;
    logic        cpu_ack, dma_ack, cpu_gnt, dma_gnt, rw;
    logic [7:0]  rdata;
    logic [15:0] addrbus;
    wire  [7:0]  databus;
    logic [7:0]  mem_data = 8'h00;

    // WAIT_STATES = 0 instance (DMA side idle)
    logic        c0_req = 0, c0_rw = 1;
    logic [15:0] c0_addr = 0;
    logic [7:0]  c0_wdata = 0;
    logic        c0_ack, d0_ack, c0_gnt, d0_gnt, rw0;
    logic [7:0]  rdata0;
    logic [15:0] addrbus0;
    wire  [7:0]  databus0;
    logic [7:0]  mem0_data = 8'h00;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Memory answers reads while a transaction owns the bus and releases it in TURN.
    assign databus  = (rw  && (cpu_gnt || dma_gnt) && !(cpu_ack || dma_ack)) ? mem_data  : 8'hzz;
    assign databus0 = (rw0 && (c0_gnt  || d0_gnt)  && !(c0_ack  || d0_ack))  ? mem0_data : 8'hzz;

    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (databus[g]);
        pullup (databus0[g]);
    end

    javk_bus_arbiter #(.WAIT_STATES(1)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_rw(dma_rw), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
        .rdata(rdata), .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt),
        .addrbus(addrbus), .rw(rw), .databus(databus)
    );

    javk_bus_arbiter #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst),
        .cpu_req(c0_req), .cpu_rw(c0_rw), .cpu_addr(c0_addr), .cpu_wdata(c0_wdata), .cpu_ack(c0_ack),
        .dma_req(1'b0), .dma_rw(1'b1), .dma_addr(16'h0000), .dma_wdata(8'h00), .dma_ack(d0_ack),
        .rdata(rdata0), .cpu_gnt(c0_gnt), .dma_gnt(d0_gnt),
        .addrbus(addrbus0), .rw(rw0), .databus(databus0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset ----------------
        tick(); tick();
        chk("rst_addrbus", 32'(addrbus), 32'h0000);
        chk("rst_rw",      32'(rw), 32'd1);
        chk("rst_databus", 32'(databus), 32'hFF);
        chk("rst_acks",    32'({cpu_ack, dma_ack}), 32'd0);
        chk("rst_gnts",    32'({cpu_gnt, dma_gnt}), 32'd0);
        chk("rst_rdata",   32'(rdata), 32'h00);
        rst = 1'b0;
        tick();
        chk("idle_gnts", 32'({cpu_gnt, dma_gnt}), 32'd0);

        // ---------------- CPU read, WS=1 ----------------
        mem_data = 8'hA5;
        cpu_req = 1; cpu_rw = 1; cpu_addr = 16'h1234;
        tick(); // E0
        chk("rd_addrbus", 32'(addrbus), 32'h1234);
        chk("rd_rw",      32'(rw), 32'd1);
        chk("rd_gnt",     32'({cpu_gnt, dma_gnt}), 32'b10);
        chk("rd_ack_e0",  32'(cpu_ack), 32'd0);
        cpu_req = 0;
        tick(); // E0+1
        chk("rd_ack_e1",  32'(cpu_ack), 32'd0);
        tick(); // E0+2
        chk("rd_ack_e2",  32'(cpu_ack), 32'd1);
        chk("rd_rdata",   32'(rdata), 32'hA5);
        chk("rd_dma_ack", 32'(dma_ack), 32'd0);
        tick(); // E0+3
        chk("rd_ack_e3",  32'(cpu_ack), 32'd0);
        chk("rd_gnt_e3",  32'({cpu_gnt, dma_gnt}), 32'd0);

        // ---------------- DMA write 3C -> FFFF ----------------
        dma_req = 1; dma_rw = 0; dma_addr = 16'hFFFF; dma_wdata = 8'h3C;
        tick(); // E0
        chk("wr_gnt",     32'({cpu_gnt, dma_gnt}), 32'b01);
        chk("wr_addrbus", 32'(addrbus), 32'hFFFF);
        chk("wr_rw_e0",   32'(rw), 32'd0);
        chk("wr_db_e0",   32'(databus), 32'h3C);
        dma_req = 0; dma_wdata = 8'h00; dma_addr = 16'h0001;
        tick(); // E0+1
        chk("wr_rw_e1",   32'(rw), 32'd0);
        chk("wr_db_e1",   32'(databus), 32'h3C);
        chk("wr_ack_e1",  32'(dma_ack), 32'd0);
        tick(); // E0+2 TURN
        chk("wr_db_turn", 32'(databus), 32'hFF);
        chk("wr_rw_turn", 32'(rw), 32'd1);
        chk("wr_ack_e2",  32'(dma_ack), 32'd1);
        chk("wr_rdata",   32'(rdata), 32'hA5);
        chk("wr_addr_turn", 32'(addrbus), 32'hFFFF);
        tick();
        chk("wr_ack_e3",  32'(dma_ack), 32'd0);

        // ---------------- both held, 4 transactions ----------------
        mem_data = 8'h77;
        cpu_req = 1; cpu_rw = 1; cpu_addr = 16'h0100;
        dma_req = 1; dma_rw = 1; dma_addr = 16'h0200;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk($sformatf("rr_cpu_ack_%0d", k), 32'(cpu_ack), 32'((k == 2) || (k == 10)));
            chk($sformatf("rr_dma_ack_%0d", k), 32'(dma_ack), 32'((k == 6) || (k == 14)));
            chk($sformatf("rr_cpu_gnt_%0d", k), 32'(cpu_gnt), 32'((k <= 2) || (k >= 8 && k <= 10)));
            chk($sformatf("rr_dma_gnt_%0d", k), 32'(dma_gnt), 32'((k >= 4 && k <= 6) || (k >= 12 && k <= 14)));
            chk($sformatf("rr_excl_%0d", k), 32'(cpu_gnt && dma_gnt), 32'd0);
            if (k == 14) begin
                cpu_req = 0; dma_req = 0;
            end
        end
        tick();
        chk("rr_idle", 32'({cpu_gnt, dma_gnt}), 32'd0);

        // ---------------- WAIT_STATES = 0 ----------------
        mem0_data = 8'h5A;
        c0_req = 1; c0_rw = 1; c0_addr = 16'h0042;
        tick(); // E0
        chk("ws0_gnt_e0",  32'(c0_gnt), 32'd1);
        chk("ws0_addr",    32'(addrbus0), 32'h0042);
        chk("ws0_ack_e0",  32'(c0_ack), 32'd0);
        tick(); // E0+1
        chk("ws0_ack_e1",  32'(c0_ack), 32'd1);
        chk("ws0_rdata",   32'(rdata0), 32'h5A);
        tick(); // E0+2 IDLE
        chk("ws0_gnt_e2",  32'(c0_gnt), 32'd0);
        chk("ws0_ack_e2",  32'(c0_ack), 32'd0);
        tick(); // E0+3 second grant
        chk("ws0_gnt_e3",  32'(c0_gnt), 32'd1);
        c0_req = 0;
        tick();
        chk("ws0_ack_e4",  32'(c0_ack), 32'd1);
        tick();
        chk("ws0_gnt_e5",  32'(c0_gnt), 32'd0);

        // ---------------- req dropped after grant ----------------
        mem_data = 8'hC3;
        cpu_req = 1; cpu_rw = 1; cpu_addr = 16'h00F0;
        tick(); // E0
        chk("drop_gnt",   32'(cpu_gnt), 32'd1);
        cpu_addr = 16'hBEEF; cpu_rw = 0;
        tick(); // E0+1
        chk("drop_addr",  32'(addrbus), 32'h00F0);
        chk("drop_rw",    32'(rw), 32'd1);
        cpu_req = 0;
        tick(); // E0+2
        chk("drop_ack",   32'(cpu_ack), 32'd1);
        chk("drop_rdata", 32'(rdata), 32'hC3);
        tick();
        chk("drop_ack_off", 32'(cpu_ack), 32'd0);
        tick(); tick();
        chk("drop_no_regrant", 32'({cpu_gnt, dma_gnt}), 32'd0);

        // ---------------- reset mid write ----------------
        cpu_req = 1; cpu_rw = 0; cpu_addr = 16'h5555; cpu_wdata = 8'h99;
        tick(); // E0
        chk("rstw_rw",   32'(rw), 32'd0);
        chk("rstw_db",   32'(databus), 32'h99);
        #2 rst = 1'b1;
        #1;
        chk("rstw_rw_now",   32'(rw), 32'd1);
        chk("rstw_db_now",   32'(databus), 32'hFF);
        chk("rstw_addr_now", 32'(addrbus), 32'h0000);
        chk("rstw_gnt_now",  32'({cpu_gnt, dma_gnt}), 32'd0);
        tick(); tick();
        chk("rstw_no_ack", 32'({cpu_ack, dma_ack}), 32'd0);
        cpu_req = 1; cpu_rw = 1; cpu_addr = 16'h0010;
        dma_req = 1; dma_rw = 1; dma_addr = 16'h0020;
        rst = 1'b0;
        tick();
        chk("rstw_first_cpu", 32'({cpu_gnt, dma_gnt}), 32'b10);
        chk("rstw_addr_cpu",  32'(addrbus), 32'h0010);
        cpu_req = 0; dma_req = 0;
        tick(); tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
